// File: rtl/mem_access_stage.sv
// Pipeline memory stage: EX->MEM register, data-memory handshake FSM, lane steering and load extension.
// Latency: request issues the cycle after the op is loaded; load result is visible combinationally in the ack cycle.
// Backpressure: stallreq_mem holds the pipe until dm_ack; stall[4] holds the stage. MEM_ALIGN_CHECK_EN adds alignment traps.
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              ex_valid,
    input  logic              ex_mem_en,
    input  logic              ex_mem_we,
    input  logic              ex_mem_signed,
    input  logic              ex_rf_we,
    input  logic [1:0]        ex_mem_size,
    input  logic [31:0]       ex_pc,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [4:0]        ex_rf_waddr,
    output logic              dm_req,
    output logic              dm_we,
    output logic [BE_W-1:0]   dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic              wb_rf_we,
    output logic [31:0]       wb_pc,
    output logic [4:0]        wb_rf_waddr,
    output logic [DATA_W-1:0] wb_rf_wdata,
    output logic              stallreq_mem
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              mem_excp,
    output logic [ADDR_W-1:0] mem_badvaddr
`endif
);

    localparam int OFF_W = $clog2(BE_W);

    typedef struct packed {
        logic              valid;
        logic              mem_en;
        logic              mem_we;
        logic              mem_signed;
        logic              rf_we;
        logic [1:0]        size;
        logic [31:0]       pc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] result;
        logic [4:0]        rf_waddr;
    } stage_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    stage_t            r;
    stage_t            ex_op;
    state_t            state;
    logic [DATA_W-1:0] ld_buf;
    logic              load_ex, load_bub, ex_go, ack_hit;
    logic              ex_misal, excp;
    logic              is_load, is_store;
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   be_raw;
    logic [DATA_W-1:0] wdata_rep, ld_src, ld_shift, ld_val;
    logic              unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

    assign ex_misal     = misaligned(ex_addr[2:0], ex_mem_size);
    assign excp         = r.valid & r.mem_en & misaligned(r.addr[2:0], r.size);
    assign mem_excp     = excp;
    assign mem_badvaddr = excp ? r.addr : '0;
`else
    assign ex_misal = 1'b0;
    assign excp     = 1'b0;
`endif

    always_comb begin
        ex_op            = '0;
        ex_op.valid      = ex_valid;
        ex_op.mem_en     = ex_mem_en;
        ex_op.mem_we     = ex_mem_we;
        ex_op.mem_signed = ex_mem_signed;
        ex_op.rf_we      = ex_rf_we;
        ex_op.size       = ex_mem_size;
        ex_op.pc         = ex_pc;
        ex_op.addr       = ex_addr;
        ex_op.wdata      = ex_wdata;
        ex_op.result     = ex_result;
        ex_op.rf_waddr   = ex_rf_waddr;
    end

    assign load_ex  = ~stall[3];
    assign load_bub = stall[3] & ~stall[4];
    assign ex_go    = load_ex & ex_valid & ex_mem_en & ~ex_misal;
    assign ack_hit  = (state == ACCESS) & dm_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            state  <= IDLE;
            ld_buf <= '0;
        end else begin
            if (load_ex)
                r <= ex_op;
            else if (load_bub)
                r <= '0;
            if (ack_hit)
                ld_buf <= dm_rdata;
            // a freshly loaded memory op always restarts the handshake, even straight out of an ack
            if (ex_go)
                state <= ACCESS;
            else if (ack_hit)
                state <= DONE;
            else if (state == DONE && (load_ex || load_bub))
                state <= IDLE;
        end
    end

    // sub-size address bits are ignored so a mis-sized address still hits an aligned lane group
    always_comb begin
        case (r.size)
            2'd0:    off = r.addr[OFF_W-1:0];
            2'd1:    off = r.addr[OFF_W-1:0] & ~OFF_W'(1);
            2'd2:    off = r.addr[OFF_W-1:0] & ~OFF_W'(3);
            default: off = '0;
        endcase
    end

    always_comb begin
        case (r.size)
            2'd0: begin
                be_raw    = BE_W'(1) << off;
                wdata_rep = {BE_W{r.wdata[7:0]}};
            end
            2'd1: begin
                be_raw    = BE_W'(3) << off;
                wdata_rep = {(BE_W/2){r.wdata[15:0]}};
            end
            2'd2: begin
                be_raw    = BE_W'(15) << off;
                wdata_rep = {(BE_W/4){r.wdata[31:0]}};
            end
            default: begin
                be_raw    = '1;
                wdata_rep = r.wdata;
            end
        endcase
    end

    assign ld_src   = ack_hit ? dm_rdata : ld_buf;
    assign ld_shift = ld_src >> {off, 3'b000};

    always_comb begin
        ld_val = ld_shift;
        case (r.size)
            2'd0:    ld_val = r.mem_signed ? DATA_W'($signed(ld_shift[7:0]))  : DATA_W'(ld_shift[7:0]);
            2'd1:    ld_val = r.mem_signed ? DATA_W'($signed(ld_shift[15:0])) : DATA_W'(ld_shift[15:0]);
            2'd2:    ld_val = r.mem_signed ? DATA_W'($signed(ld_shift[31:0])) : DATA_W'(ld_shift[31:0]);
            default: ld_val = ld_shift;
        endcase
    end

    assign is_load  = r.valid & r.mem_en & ~r.mem_we;
    assign is_store = r.valid & r.mem_en & r.mem_we;

    assign dm_req       = (state == ACCESS);
    assign dm_we        = dm_req & r.mem_we;
    assign dm_be        = dm_req ? be_raw : '0;
    assign dm_addr      = dm_req ? r.addr : '0;
    assign dm_wdata     = dm_req ? wdata_rep : '0;
    assign stallreq_mem = (state == ACCESS) & ~dm_ack;

    assign wb_valid    = r.valid;
    assign wb_pc       = r.pc;
    assign wb_rf_waddr = r.rf_waddr;
    assign wb_rf_wdata = is_load ? ld_val : r.result;
    assign wb_rf_we    = r.valid & r.rf_we & ~is_store & ~stallreq_mem & ~excp;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (DATA_W=32): directed scenarios then random ops against a transaction-level model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_valid, ex_mem_en, ex_mem_we, ex_mem_signed, ex_rf_we;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_pc, ex_addr, ex_wdata, ex_result;
    logic [4:0]  ex_rf_waddr;
    logic        dm_req, dm_we, dm_ack;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        wb_valid, wb_rf_we, stallreq_mem;
    logic [31:0] wb_pc, wb_rf_wdata;
    logic [4:0]  wb_rf_waddr;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_excp;
    logic [31:0] mem_badvaddr;
`endif

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_valid(ex_valid), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we),
        .ex_mem_signed(ex_mem_signed), .ex_rf_we(ex_rf_we), .ex_mem_size(ex_mem_size),
        .ex_pc(ex_pc), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
        .ex_rf_waddr(ex_rf_waddr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_pc(wb_pc), .wb_rf_waddr(wb_rf_waddr),
        .wb_rf_wdata(wb_rf_wdata), .stallreq_mem(stallreq_mem)
`ifdef MEM_ALIGN_CHECK_EN
        , .mem_excp(mem_excp), .mem_badvaddr(mem_badvaddr)
`endif
    );

    typedef struct {
        bit        valid, mem_en, we, sgn, rf_we;
        bit [1:0]  size;
        bit [31:0] pc, addr, wdata, result, rdata;
        bit [4:0]  waddr;
        int        waits;
    } op_t;

    int   total = 0;
    int   bad   = 0;
    op_t  cur;
    bit   acked;
    int   wl;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_rfw;
    logic        s_sr, s_req, s_rfwe;
`ifdef MEM_ALIGN_CHECK_EN
    logic        s_excp;
    logic [31:0] s_bad;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic op_t bubble();
        op_t o;
        o = '{default: 0};
        return o;
    endfunction

    function automatic op_t mk(bit we, bit sgn, bit [1:0] size, bit [31:0] addr,
                               bit [31:0] wdata, bit [31:0] rdata, int waits);
        op_t o;
        o = bubble();
        o.valid = 1; o.mem_en = 1; o.we = we; o.sgn = sgn; o.rf_we = 1;
        o.size = size; o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.waits = waits;
        o.pc = $urandom; o.result = $urandom; o.waddr = 5'($urandom);
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        int  k;
        k = $urandom_range(0, 3);
        if (k == 0) return bubble();
        o = mk(k == 3, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
               $urandom_range(0, 3));
        if (k == 1) o.mem_en = 0;
        if (k == 3) o.rf_we = 1'($urandom);
        return o;
    endfunction

    function automatic int nb(bit [1:0] s);
        return 1 << s;
    endfunction

    function automatic int lane(op_t o);
        int a;
        a = o.addr % 4;
        return (a / nb(o.size)) * nb(o.size);
    endfunction

    function automatic bit [3:0] exp_be(op_t o);
        int t;
        t = ((1 << nb(o.size)) - 1) << lane(o);
        return t[3:0];
    endfunction

    function automatic bit [31:0] exp_wd(op_t o);
        bit [63:0] m, v, res;
        int n;
        n = nb(o.size);
        m = (64'd1 << (8 * n)) - 1;
        v = 64'(o.wdata) & m;
        res = 0;
        for (int k = 0; k < 4; k += n) res |= v << (8 * k);
        return res[31:0];
    endfunction

    function automatic bit [31:0] exp_ld(op_t o);
        bit [63:0] m, v;
        int n;
        n = nb(o.size);
        m = (64'd1 << (8 * n)) - 1;
        v = (64'(o.rdata) >> (8 * lane(o))) & m;
        if (o.sgn && v[8*n-1]) v |= ~m;
        return v[31:0];
    endfunction

    function automatic bit misal(op_t o);
`ifdef MEM_ALIGN_CHECK_EN
        return o.valid && o.mem_en && (o.addr % nb(o.size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(op_t o);
        ex_valid = o.valid; ex_mem_en = o.mem_en; ex_mem_we = o.we; ex_mem_signed = o.sgn;
        ex_rf_we = o.rf_we; ex_mem_size = o.size; ex_pc = o.pc; ex_addr = o.addr;
        ex_wdata = o.wdata; ex_result = o.result; ex_rf_waddr = o.waddr;
    endtask

    // One cycle: present o, answer memory, check the op currently in the stage, then advance the model.
    task automatic step(op_t o, bit s3, bit s4, bit do_rst);
        bit exp_req, ack_now, exp_sr, eff3, eff4, is_ld, is_st;
        drive(o);
        rst = do_rst;
        @(negedge clk);
        exp_req  = cur.valid && cur.mem_en && !acked && !misal(cur);
        ack_now  = exp_req && (wl == 0);
        dm_ack   = ack_now;
        dm_rdata = ack_now ? cur.rdata : $urandom;
        exp_sr   = exp_req && !ack_now;
        eff4     = s4 | exp_sr;
        eff3     = s3 | eff4;
        stall    = {1'b0, eff4, eff3, eff3, eff3, eff3};
        #1;
        chk("dm_req", dm_req, exp_req);
        chk("stallreq", stallreq_mem, exp_sr);
        if (exp_req) begin
            chk("dm_we", dm_we, cur.we);
            chk("dm_addr", dm_addr, cur.addr);
            chk("dm_be", dm_be, exp_be(cur));
            if (cur.we) chk("dm_wdata", dm_wdata, exp_wd(cur));
        end
        chk("wb_valid", wb_valid, cur.valid);
        chk("wb_pc", wb_pc, cur.pc);
        chk("wb_waddr", wb_rf_waddr, cur.waddr);
        is_st = cur.valid && cur.mem_en && cur.we;
        is_ld = cur.valid && cur.mem_en && !cur.we;
        chk("wb_rf_we", wb_rf_we, cur.rf_we && !is_st && !exp_sr && !misal(cur));
        if (!is_ld)
            chk("wb_wdata_alu", wb_rf_wdata, cur.result);
        else if (acked || ack_now)
            chk("wb_wdata_ld", wb_rf_wdata, exp_ld(cur));
`ifdef MEM_ALIGN_CHECK_EN
        chk("mem_excp", mem_excp, misal(cur));
        if (misal(cur)) chk("badvaddr", mem_badvaddr, cur.addr);
        s_excp = mem_excp; s_bad = mem_badvaddr;
`endif
        s_be = dm_be; s_wd = dm_wdata; s_sr = stallreq_mem; s_req = dm_req;
        s_rfw = wb_rf_wdata; s_rfwe = wb_rf_we;
        @(posedge clk);
        if (do_rst) begin
            cur = bubble(); acked = 0; wl = 0;
        end else begin
            if (ack_now) acked = 1;
            else if (exp_req) wl--;
            if (!eff3) begin
                cur = o; acked = 0; wl = o.waits;
            end else if (!eff4) begin
                cur = bubble(); acked = 0; wl = 0;
            end
        end
        #1;
        dm_ack = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, dm_req, 0);
        chk({tag, "_we"}, dm_we, 0);
        chk({tag, "_be"}, dm_be, 0);
        chk({tag, "_addr"}, dm_addr, 0);
        chk({tag, "_wdata"}, dm_wdata, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_wbwe"}, wb_rf_we, 0);
        chk({tag, "_wbpc"}, wb_pc, 0);
        chk({tag, "_wbwa"}, wb_rf_waddr, 0);
        chk({tag, "_wbwd"}, wb_rf_wdata, 0);
        chk({tag, "_sr"}, stallreq_mem, 0);
    endtask

    initial begin
        op_t a, b, st;
        int  sr;
        rst = 1; stall = 0; dm_ack = 0; dm_rdata = 0;
        cur = bubble(); acked = 0; wl = 0;
        drive(bubble());
        @(posedge clk); #1;
        step(bubble(), 0, 0, 1);
        chk_zero("reset");

        // signed byte load, zero-wait ack
        a = mk(0, 1, 2'd0, 32'h0000_1003, 0, 32'h80FF_FF00, 0);
        step(a, 0, 0, 0);
        step(bubble(), 0, 0, 0);
        chk("sb_result", s_rfw, 32'hFFFF_FF80);
        chk("sb_stallreq", s_sr, 0);
        step(bubble(), 0, 0, 0);

        // half store with three wait states
        st = mk(1, 0, 2'd1, 32'h0000_2002, 32'h0000_1234, 0, 3);
        step(st, 0, 0, 0);
        sr = 0;
        for (int i = 0; i < 4; i++) begin
            step(bubble(), 0, 0, 0);
            chk("sh_be", s_be, 4'b1100);
            chk("sh_wdata", s_wd, 32'h1234_1234);
            chk("sh_rfwe", s_rfwe, 0);
            sr += int'(s_sr);
        end
        chk("sh_stall_cycles", sr, 3);

        // unsigned half load acked while downstream is held
        a = mk(0, 0, 2'd1, 32'h0000_4002, 0, 32'hABCD_1234, 0);
        step(a, 0, 0, 0);
        step(bubble(), 1, 1, 0);
        chk("lhu_ack_result", s_rfw, 32'h0000_ABCD);
        step(bubble(), 1, 1, 0);
        chk("lhu_done_req", s_req, 0);
        chk("lhu_done_result", s_rfw, 32'h0000_ABCD);
        step(bubble(), 0, 0, 0);
        chk("lhu_release_result", s_rfw, 32'h0000_ABCD);
        step(bubble(), 0, 0, 0);

        // back-to-back zero-wait loads
        a = mk(0, 0, 2'd2, 32'h0000_5000, 0, 32'hDEAD_BEEF, 0);
        b = mk(0, 0, 2'd0, 32'h0000_5001, 0, 32'h0000_AB00, 0);
        step(a, 0, 0, 0);
        step(b, 0, 0, 0);
        chk("b2b_first", s_rfw, 32'hDEAD_BEEF);
        step(bubble(), 0, 0, 0);
        chk("b2b_second_req", s_req, 1);
        chk("b2b_second", s_rfw, 32'h0000_00AB);
        step(bubble(), 0, 0, 0);

        // reset in the second ACCESS cycle
        a = mk(0, 0, 2'd2, 32'h0000_6000, 0, 32'h1111_2222, 3);
        step(a, 0, 0, 0);
        step(bubble(), 0, 0, 0);
        step(bubble(), 0, 0, 1);
        chk("rst_pre_req", s_req, 1);
        chk_zero("rst_access");
        step(bubble(), 0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
        a = mk(0, 0, 2'd2, 32'h0000_3001, 0, 32'h0, 0);
        step(a, 0, 0, 0);
        step(bubble(), 0, 0, 0);
        chk("mis_req", s_req, 0);
        chk("mis_excp", s_excp, 1);
        chk("mis_bad", s_bad, 32'h0000_3001);
        chk("mis_rfwe", s_rfwe, 0);
`endif

        for (int i = 0; i < 400; i++)
            step(rnd_op(), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(bubble(), 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-003 SHALL have parameter BE_W, default DATA_W/8, byte-lane count; BE_W is derived and SHALL NOT be overridden.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 stall  in  6  pipeline stall vector; bit3 holds this stage, bit4 holds the downstream stage.
REQ-007 ex_valid, ex_mem_en, ex_mem_we, ex_mem_signed, ex_rf_we  in  1 each  EX-stage op qualifiers.
REQ-008 ex_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
REQ-009 ex_pc  in  32; ex_addr  in  ADDR_W; ex_wdata and ex_result  in  DATA_W; ex_rf_waddr  in  5.
REQ-010 dm_req, dm_we  out  1; dm_be  out  BE_W; dm_addr  out  ADDR_W; dm_wdata  out  DATA_W  data-memory request.
REQ-011 dm_ack  in  1; dm_rdata  in  DATA_W  data-memory response.
REQ-012 wb_valid, wb_rf_we  out  1; wb_pc  out  32; wb_rf_waddr  out  5; wb_rf_wdata  out  DATA_W  WB-stage bus and forwarding path.
REQ-013 stallreq_mem  out  1  pipeline stall request.

Function
REQ-014 Stage register SHALL load the EX inputs when stall[3]=0.
REQ-015 Stage register SHALL load a bubble (all fields 0) when stall[3]=1 and stall[4]=0, and SHALL hold otherwise.
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 FSM SHALL enter ACCESS on any edge that loads a valid op with ex_mem_en=1; this rule takes priority over every other transition.
REQ-018 FSM SHALL go ACCESS->DONE on an edge with dm_ack=1.
REQ-019 FSM SHALL go DONE->IDLE when the register loads a non-memory op or a bubble.
REQ-020 dm_req SHALL be 1 only in ACCESS, and SHALL hold dm_we/dm_be/dm_addr/dm_wdata stable until dm_ack.
REQ-021 dm_ack in the first ACCESS cycle SHALL be legal (zero wait states).
REQ-022 stallreq_mem SHALL equal (state==ACCESS and dm_ack=0), combinationally.
REQ-023 On ack, dm_rdata SHALL be latched into ld_buf; ld_buf SHALL stay valid in DONE while stall[4]=1.
REQ-024 dm_be: byte = one lane at addr[log2(BE_W)-1:0]; half = two lanes; word = four lanes; dword = all lanes.
REQ-025 dm_wdata SHALL replicate the low 8/16/32 bits of the store data across all lanes.
REQ-026 Load result SHALL select the addressed lane(s) of ld_buf (or of dm_rdata in the ack cycle) and sign-extend when ex_mem_signed=1, zero-extend otherwise.
REQ-027 wb_rf_wdata SHALL be the load result for loads and ex_result otherwise.
REQ-028 wb_rf_we SHALL be forced 0 for stores and while stallreq_mem=1.
REQ-029 dm_addr SHALL be the full address; lane selection uses the low bits only.

Reset
REQ-030 rst SHALL force the register to a bubble, FSM to IDLE, and ld_buf to 0.
REQ-031 After rst, all outputs SHALL be 0 from the next cycle.
REQ-032 rst during ACCESS SHALL abandon the request; the memory side SHALL tolerate the dropped dm_req.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN SHALL enable the alignment check, adding outputs mem_excp (1) and mem_badvaddr (ADDR_W).
REQ-034 With MEM_ALIGN_CHECK_EN, a misaligned access SHALL skip ACCESS, raise mem_excp, drive mem_badvaddr=address, and force wb_rf_we=0.
REQ-035 Without MEM_ALIGN_CHECK_EN, these ports SHALL be absent and the low address bits below the access size SHALL be treated as zero.

Verification
REQ-036 Signed byte load addr 0x1003, rdata 0x80FF_FF00, ack in cycle 1 -> wb_rf_wdata=0xFFFF_FF80, stallreq_mem 0 throughout.
REQ-037 Half store addr 0x2002, data 0x1234, 3 wait cycles -> dm_be=1100 and dm_wdata=0x1234_1234 stable for 4 cycles; stallreq_mem=1 for 3 cycles; wb_rf_we=0.
REQ-038 Unsigned half load acked while stall[4]=1 for 2 cycles -> wb_rf_wdata holds zero-extended data; FSM stays DONE, then returns to IDLE.
REQ-039 Back-to-back loads with zero-wait ack -> FSM ACCESS->ACCESS; each result appears one cycle apart.
REQ-040 rst asserted in the second ACCESS cycle -> dm_req=0 and all outputs 0 on the next cycle.
REQ-041 With MEM_ALIGN_CHECK_EN, word load addr 0x3001 -> dm_req stays 0, mem_excp=1, mem_badvaddr=0x3001.
